// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small decode helpers used by both the datapath and the control.
package md_defs;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   function automatic logic is_mul(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Purely combinational multiply/divide datapath. Produces the HI/LO pair for
// the selected op and flags a zero divisor so the caller can skip the write.
module md_arith
   import md_defs::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_zero
);

   logic        sgn;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] safe_b;
   logic [31:0] uq;
   logic [31:0] ur;

   // Signed ops work on magnitudes; the min/-1 case falls out naturally as
   // 0x80000000 with remainder 0 because the magnitude of 0x80000000 is itself.
   always_comb begin
      sgn      = (op == MD_MULT) || (op == MD_DIV);
      ext_a    = {(sgn ? {32{a[31]}} : 32'd0), a};
      ext_b    = {(sgn ? {32{b[31]}} : 32'd0), b};
      prod     = ext_a * ext_b;
      mag_a    = (sgn && a[31]) ? (32'd0 - a) : a;
      mag_b    = (sgn && b[31]) ? (32'd0 - b) : b;
      div_zero = (b == 32'd0);
      safe_b   = div_zero ? 32'd1 : mag_b;
      uq       = mag_a / safe_b;
      ur       = mag_a % safe_b;
      res_hi   = 32'd0;
      res_lo   = 32'd0;
      if (is_mul(op)) begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (is_div(op)) begin
         // Quotient truncates toward zero; remainder follows the dividend sign.
         res_lo = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
         res_hi = (sgn && a[31]) ? (32'd0 - ur) : ur;
      end
   end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit. Holds HI/LO, runs MULT/DIV with a fixed
// busy period and applies the result on the final cycle. Handshake: an op is
// taken at a rising edge where start=1 and busy=0; while busy=1 start is
// ignored and HI/LO keep their pre-operation values until busy drops.
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_op_e           op;
   md_state_e        state_q;
   md_state_e        state_next;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_we;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             div_zero;
   logic             accept;
   logic             commit;
   logic             mthi_we;
   logic             mtlo_we;

   assign op = md_op_e'(md_op);

   md_arith u_arith (
      .op       (op),
      .a        (rs_val),
      .b        (rt_val),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   // State register: FSM state, countdown and the pending result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_we <= 1'b0;
      end else begin
         state_q <= state_next;
         cnt_q   <= cnt_next;
         if (accept) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= !(is_div(op) && div_zero);
         end
      end
   end

   // Next-state: load the countdown on accept, decrement while running.
   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_next   = is_mul(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_next = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs/enables: accept, completion write and MTHI/MTLO writes.
   always_comb begin
      accept  = start && (state_q == ST_IDLE) && (is_mul(op) || is_div(op));
      commit  = (state_q == ST_RUN) && (cnt_q == CNT_W'(1)) && pend_we;
      mthi_we = start && (state_q == ST_IDLE) && (op == MD_MTHI);
      mtlo_we = start && (state_q == ST_IDLE) && (op == MD_MTLO);
   end

   // HI/LO registers; completion and MT writes never coincide (RUN vs IDLE).
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (commit)       hi <= pend_hi;
         else if (mthi_we) hi <= rs_val;
         if (commit)       lo <= pend_lo;
         else if (mtlo_we) lo <= rs_val;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign md_rdata = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed ops push expected HI/LO and busy length into a
// queue; a monitor pops and compares each time busy falls.
module tb_md_unit;
   import md_defs::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hilo_sel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_rdata;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   flush        = 1'b0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .hilo_sel(hilo_sel),
      .busy(busy), .hi(hi), .lo(lo), .md_rdata(md_rdata)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      @(posedge clk);
      #1 start = 1'b0; md_op = MD_NONE;
   endtask

   task automatic issue_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input int cyc,
                            input string name);
      exp_t e;
      e.hi = ehi; e.lo = elo; e.cycles = cyc; e.name = name;
      exp_q.push_back(e);
      issue(op, a, b);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (busy) begin
         tests_failed++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
      end
   endtask

   // monitor / scoreboard
   initial begin
      int   busy_cnt  = 0;
      logic prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            busy_cnt++;
         end else if (prev_busy === 1'b1) begin
            if (flush) begin
               flush = 1'b0;
            end else if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_done: completion with empty queue, hi=0x%08h lo=0x%08h", hi, lo);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_hi"}, hi, e.hi);
               check({e.name, "_lo"}, lo, e.lo);
               check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
            end
            busy_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; md_op = MD_NONE;
      rs_val = '0; rt_val = '0; hilo_sel = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      issue_exp(MD_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult_neg");
      wait_idle("mult_neg");
      issue_exp(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, "multu");
      wait_idle("multu");
      issue_exp(MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
      wait_idle("div_neg");
      issue_exp(MD_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div_negdivisor");
      wait_idle("div_negdivisor");
      issue_exp(MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
      wait_idle("divu");
      issue_exp(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, "div_ovf");
      wait_idle("div_ovf");

      // MTHI/MTLO: immediate writes, no busy period
      issue(MD_MTHI, 32'h1234, 32'd0);
      issue(MD_MTLO, 32'h5678, 32'd0);
      @(negedge clk);
      check("mt_busy", {31'd0, busy}, 32'd0);
      check("mthi", hi, 32'h1234);
      check("mtlo", lo, 32'h5678);
      hilo_sel = 1'b0; #1 check("rdata_lo", md_rdata, 32'h5678);
      hilo_sel = 1'b1; #1 check("rdata_hi", md_rdata, 32'h1234);

      // divide by zero keeps HI/LO
      issue_exp(MD_DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, "div_zero");
      wait_idle("div_zero");
      hilo_sel = 1'b0; #1 check("dz_rdata_lo", md_rdata, 32'h5678);
      hilo_sel = 1'b1; #1 check("dz_rdata_hi", md_rdata, 32'h1234);

      // undefined op with start: no effect
      issue(MD_RSVD, 32'hDEAD, 32'hBEEF);
      @(negedge clk);
      check("rsvd_busy", {31'd0, busy}, 32'd0);
      check("rsvd_hi", hi, 32'h1234);

      // MTLO during busy is ignored; lo keeps old value while busy
      issue_exp(MD_MULT, 32'd3, 32'd7, 32'd0, 32'h15, 5, "mult_ignore_mt");
      issue(MD_MTLO, 32'hAAAA, 32'd0);
      @(negedge clk);
      check("busy_lo_held", lo, 32'h5678);
      wait_idle("mult_ignore_mt");

      // start on the completion edge is ignored
      issue_exp(MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 10, "divu_edge");
      repeat (10) @(negedge clk);
      start = 1'b1; md_op = MD_MTHI; rs_val = 32'hBEEF;
      @(posedge clk);
      #1 start = 1'b0; md_op = MD_NONE;
      wait_idle("divu_edge");
      check("edge_hi", hi, 32'd1);

      // reset mid-operation aborts
      issue(MD_DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (12) @(negedge clk);
      check("abort_late_hi", hi, 32'd0);
      check("abort_late_lo", lo, 32'd0);
      check("abort_late_busy", {31'd0, busy}, 32'd0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
